// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and default decode masks for the CPU data-port router
package mem_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_bus_state_t;

  localparam int SEL_MEM    = 0;
  localparam int SEL_SPRITE = 2;
  localparam int SEL_UART   = 3;

  localparam logic [3:0] DEF_PRESENT  = 4'b1101;
  localparam logic [3:0] DEF_READABLE = 4'b1001;
  localparam logic [3:0] DEF_WRITABLE = 4'b0101;

endpackage

// File: rtl/mem_bus_router_if.sv
// rtl/mem_bus_router_if.sv - CPU-side and target-side bus signals of the router
interface mem_bus_router_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LOCAL_AW   = 10,
  parameter int NUM_SLAVES = 4
);
  logic                           MR_i;
  logic                           MW_i;
  logic [ADDR_W-1:0]              address_i;
  logic [DATA_W-1:0]              data_i;
  logic [DATA_W-1:0]              data_o;
  logic                           ready_o;
  logic                           err_o;
  logic [NUM_SLAVES-1:0]          slv_MR_o;
  logic [NUM_SLAVES-1:0]          slv_MW_o;
  logic [NUM_SLAVES*LOCAL_AW-1:0] slv_address_o;
  logic [NUM_SLAVES*DATA_W-1:0]   slv_data_o;
  logic [NUM_SLAVES*DATA_W-1:0]   slv_data_i;
  logic [NUM_SLAVES-1:0]          slv_ready_i;
  logic [7:0]                     err_count_o;

  modport slave (
    input  MR_i, MW_i, address_i, data_i, slv_data_i, slv_ready_i,
    output data_o, ready_o, err_o, slv_MR_o, slv_MW_o, slv_address_o, slv_data_o, err_count_o
  );

  modport master (
    output MR_i, MW_i, address_i, data_i, slv_data_i, slv_ready_i,
    input  data_o, ready_o, err_o, slv_MR_o, slv_MW_o, slv_address_o, slv_data_o, err_count_o
  );
endinterface

// File: rtl/mem_bus_timeout.sv
// rtl/mem_bus_timeout.sv - wait-state counter with clear, enable and terminal-count flag
module mem_bus_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign done = (count == CW'(TIMEOUT));

  // Holds at the terminal value so a late enable cannot wrap it back to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/mem_bus_router.sv
// rtl/mem_bus_router.sv - registered CPU data-port decoder routing each access to one target
module mem_bus_router
  import mem_bus_pkg::*;
#(
  parameter int                    DATA_W     = 32,
  parameter int                    ADDR_W     = 32,
  parameter int                    LOCAL_AW   = 10,
  parameter int                    SEL_W      = 2,
  parameter int                    NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES-1:0] PRESENT    = DEF_PRESENT,
  parameter logic [NUM_SLAVES-1:0] READABLE   = DEF_READABLE,
  parameter logic [NUM_SLAVES-1:0] WRITABLE   = DEF_WRITABLE,
  parameter int                    TIMEOUT    = 15
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_bus_router_if.slave  bus
);
  mem_bus_state_t state, state_nxt;

  logic [LOCAL_AW-1:0] addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [SEL_W-1:0]    sel_q;
  logic                wr_q;
  logic                err_q;
  logic [7:0]          err_cnt_q;

  logic [SEL_W-1:0]    sel_in;
  logic                req;
  logic                illegal;
  logic                sel_ready;
  logic                to_done;
  logic                enter_access;
  logic                resp_err;
  logic                unused_addr;

  assign sel_in      = bus.address_i[LOCAL_AW +: SEL_W];
  assign req         = bus.MR_i | bus.MW_i;
  assign illegal     = (bus.MR_i & bus.MW_i) | !PRESENT[sel_in]
                     | (bus.MR_i & !READABLE[sel_in]) | (bus.MW_i & !WRITABLE[sel_in]);
  assign sel_ready   = bus.slv_ready_i[sel_q];
  assign unused_addr = ^bus.address_i[ADDR_W-1:LOCAL_AW+SEL_W];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Target ready takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_nxt    = state;
    enter_access = 1'b0;
    resp_err     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (illegal) begin
            state_nxt = RESP;
            resp_err  = 1'b1;
          end else begin
            state_nxt    = ACCESS;
            enter_access = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          state_nxt = RESP;
        end else if (to_done) begin
          state_nxt = RESP;
          resp_err  = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  mem_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (enter_access),
    .en    ((state == ACCESS) && !sel_ready),
    .done  (to_done)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      sel_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (state == IDLE && req) begin
        addr_q  <= bus.address_i[LOCAL_AW-1:0];
        wdata_q <= bus.data_i;
        sel_q   <= sel_in;
        wr_q    <= bus.MW_i;
      end
      // data_o and err_o move only on the transition into RESP.
      if (state != RESP && state_nxt == RESP) begin
        err_q   <= resp_err;
        rdata_q <= (state == ACCESS && sel_ready && !wr_q)
                   ? bus.slv_data_i[sel_q*DATA_W +: DATA_W] : '0;
      end
      if (resp_err && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    bus.slv_MR_o      = '0;
    bus.slv_MW_o      = '0;
    bus.slv_address_o = '0;
    bus.slv_data_o    = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (state == ACCESS && sel_q == SEL_W'(s)) begin
        bus.slv_MR_o[s]                           = !wr_q;
        bus.slv_MW_o[s]                           = wr_q;
        bus.slv_address_o[s*LOCAL_AW +: LOCAL_AW] = addr_q;
        bus.slv_data_o[s*DATA_W +: DATA_W]        = wdata_q;
      end
    end
  end

  assign bus.ready_o     = (state == RESP);
  assign bus.err_o       = err_q;
  assign bus.data_o      = rdata_q;
  assign bus.err_count_o = err_cnt_q;
endmodule

// File: tb/tb_mem_bus_router.sv
// tb/tb_mem_bus_router.sv - scoreboard bench for mem_bus_router
module tb_mem_bus_router;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LAW = 10;
  localparam int NS  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   exp_cnt  = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  mem_bus_router_if #(.DATA_W(DW), .ADDR_W(AW), .LOCAL_AW(LAW), .NUM_SLAVES(NS)) bus ();

  mem_bus_router #(
    .DATA_W(DW), .ADDR_W(AW), .LOCAL_AW(LAW), .SEL_W(2), .NUM_SLAVES(NS),
    .PRESENT(4'b1101), .READABLE(4'b1001), .WRITABLE(4'b0101), .TIMEOUT(15)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.MR_i        = 1'b0;
    bus.MW_i        = 1'b0;
    bus.address_i   = '0;
    bus.data_i      = '0;
    bus.slv_data_i  = '0;
    bus.slv_ready_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  bus.ready_o, 0);
    check({tag, "_err"},    bus.err_o, 0);
    check({tag, "_data"},   bus.data_o, 0);
    check({tag, "_cnt"},    bus.err_count_o, 0);
    check({tag, "_strb"},   {bus.slv_MR_o, bus.slv_MW_o}, 0);
    check({tag, "_saddr"},  bus.slv_address_o, 0);
    check({tag, "_sdata"},  bus.slv_data_o, 0);
  endtask

  // wait_cyc: ACCESS cycles before target ready (-1 = never); exp_lat: edges from accept to ready_o.
  task automatic access(input logic mr, input logic mw, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int wait_cyc, input int exp_lat, input logic exp_err);
    int           sel   = int'(addr[11:10]);
    int           edges = 0;
    int           acc   = 0;
    logic         seen  = 1'b0;
    logic [3:0]   onehot;
    logic [39:0]  exp_abus;
    logic [127:0] exp_dbus;
    logic [127:0] rbus;
    exp_t         e;
    exp_t         got;
    onehot   = 4'b0001 << sel;
    exp_abus = 40'(addr[9:0]) << (sel * 10);
    exp_dbus = 128'(wdata) << (sel * 32);
    rbus     = {4{~rdata}};
    rbus[sel*32 +: 32] = rdata;
    e.err  = exp_err;
    e.data = (exp_err || mw) ? 32'h0 : rdata;
    exp_q.push_back(e);
    if (exp_err && exp_cnt < 255) exp_cnt++;

    @(negedge clk);
    bus.MR_i      = mr;
    bus.MW_i      = mw;
    bus.address_i = addr;
    bus.data_i    = wdata;
    while (!seen && edges < 64) begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        bus.address_i = ~addr;
        bus.data_i    = ~wdata;
      end
      if (bus.ready_o) begin
        seen = 1'b1;
        check("latency", edges, exp_lat);
        check("access_cycles", acc, exp_lat - 1);
        check("resp_strobes", {bus.slv_MR_o, bus.slv_MW_o}, 0);
        check("err_count", bus.err_count_o, exp_cnt);
        check("sb_size", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          check("err_o", bus.err_o, got.err);
          check("data_o", bus.data_o, got.data);
        end
        bus.MR_i        = 1'b0;
        bus.MW_i        = 1'b0;
        bus.slv_ready_i = '0;
        bus.slv_data_i  = '0;
      end else if (bus.slv_MR_o != 0 || bus.slv_MW_o != 0) begin
        acc++;
        if (acc == 1) begin
          check("slv_MR", bus.slv_MR_o, mr ? onehot : 4'b0);
          check("slv_MW", bus.slv_MW_o, mw ? onehot : 4'b0);
          check("slv_addr", bus.slv_address_o, exp_abus);
          if (mw) check("slv_wdata", bus.slv_data_o, exp_dbus);
        end
        bus.slv_data_i  = rbus;
        bus.slv_ready_i = (wait_cyc >= 0 && acc > wait_cyc) ? onehot : ~onehot;
      end
    end
    check("resp_seen", seen, 1);
    @(negedge clk);
    check("ready_pulse", bus.ready_o, 0);
  endtask

  initial begin
    int acc;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    access(1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 0, 2, 1'b0);
    access(1'b0, 1'b1, 32'h0000_0808, 32'h0000_1234, 32'h5555_AAAA, 3, 5, 1'b0);

    access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h1111_1111, -1, 1, 1'b1);
    access(1'b0, 1'b1, 32'h0000_0C00, 32'h0000_0099, 32'h0, -1, 1, 1'b1);
    access(1'b1, 1'b1, 32'h0000_0004, 32'h0000_0077, 32'h2222_2222, -1, 1, 1'b1);
    check("err_count_3", bus.err_count_o, 3);

    access(1'b1, 1'b0, 32'h0000_0C10, 32'h0, 32'h3333_3333, -1, 17, 1'b1);
    access(1'b1, 1'b0, 32'h0000_0C10, 32'h0, 32'hA5A5_0003, 15, 17, 1'b0);

    // Reset during the second ACCESS cycle discards the pending response.
    @(negedge clk);
    bus.MR_i      = 1'b1;
    bus.address_i = 32'h0000_0010;
    acc = 0;
    for (int i = 0; i < 10 && acc < 2; i++) begin
      @(negedge clk);
      if (bus.slv_MR_o != 0) acc++;
    end
    check("rst_reached_access2", acc, 2);
    rst      = 1'b1;
    bus.MR_i = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst     = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    check("midrst_no_ready", bus.ready_o, 0);
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1, 3, 1'b0);

    for (int i = 0; i < 260; i++) begin
      case (i % 3)
        0:       access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0, -1, 1, 1'b1);
        1:       access(1'b0, 1'b1, 32'h0000_0C00, 32'h1, 32'h0, -1, 1, 1'b1);
        default: access(1'b1, 1'b1, 32'h0000_0008, 32'h2, 32'h0, -1, 1, 1'b1);
      endcase
    end
    check("err_count_sat", bus.err_count_o, 255);
    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_bus_router.md
# mem_bus_router

Parametrised, registered successor to the CPU data-port address decoder. It sits between the CPU load/store port and NUM_SLAVES memory-mapped targets (data RAM, sprite manager, UART, ...). Each access is decoded on a selector field of the address and routed to exactly one target through a request/ready handshake with per-target wait states. Unmapped or illegal accesses, and targets that do not answer within a timeout, return an error response instead of stale data.

## Interface
- DATA_W, 32, data width
- ADDR_W, 32, CPU address width
- LOCAL_AW, 10, target-local address width (address_i[LOCAL_AW-1:0])
- SEL_W, 2, selector width; selector = address_i[LOCAL_AW+SEL_W-1:LOCAL_AW]
- NUM_SLAVES, 4, must equal 2**SEL_W
- PRESENT, 4'b1101, bit s set: selector s is mapped
- READABLE, 4'b1001, bit s set: target s accepts MR
- WRITABLE, 4'b0101, bit s set: target s accepts MW
- TIMEOUT, 15, maximum ACCESS cycles without target ready (at least 1)

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- MR_i, MW_i  in  1 each  CPU read / write request, held until ready_o
- address_i  in  ADDR_W  CPU address
- data_i  in  DATA_W  CPU write data
- data_o  out  DATA_W  registered read data
- ready_o  out  1  one-cycle response strobe
- err_o  out  1  error flag, valid while ready_o is high
- slv_MR_o, slv_MW_o  out  NUM_SLAVES  per-target strobes
- slv_address_o  out  NUM_SLAVES*LOCAL_AW  per-target local address, zero when not selected
- slv_data_o  out  NUM_SLAVES*DATA_W  per-target write data, zero when not selected
- slv_data_i  in  NUM_SLAVES*DATA_W  per-target read data
- slv_ready_i  in  NUM_SLAVES  per-target completion
- err_count_o  out  8  saturating count of error responses

## Operation
- FSM states are IDLE, ACCESS and RESP. Reset state is IDLE.
- IDLE, with MR_i or MW_i high:
  - Latch the address, data, selector and direction.
  - Raise an error and go directly to RESP if any of these holds: MR_i and MW_i are both high; the selector is not PRESENT; a read targets a non-READABLE selector; a write targets a non-WRITABLE selector.
  - Otherwise go to ACCESS.
- ACCESS:
  - Drive slv_MR_o[sel] or slv_MW_o[sel], the local address and the write data for the selected target only. All other target outputs are 0.
  - When slv_ready_i[sel] is high, capture slv_data_i[sel] on reads (0 on writes), set err=0 and go to RESP.
  - Otherwise increment the timeout counter. When the counter equals TIMEOUT, set err=1 and go to RESP.
  - If ready and timeout occur in the same cycle, ready wins.
- RESP:
  - ready_o=1 and err_o=err. data_o holds the captured data, which is 0 on error or write.
  - err_count_o increments on error and saturates at 255.
  - Always return to IDLE. A request still held in IDLE is treated as a new access, so the CPU must drop its request at the edge that ends ready_o.
- Changes on address_i and data_i after the accept cycle are ignored.
- Slave strobes are level signals during ACCESS only. A target must not assume the strobe is a single pulse.

## Timing
- Reset values: ready_o=0, err_o=0, data_o=0, err_count_o=0, all slv_* outputs 0, timeout counter 0.
- Reset mid-access returns to IDLE next cycle. Strobes drop in that cycle and the pending response is discarded.
- Request is high at edge 0 (accepted in IDLE). ACCESS begins after edge 0.
  - Fastest OK path: target ready in the first ACCESS cycle, ready_o high in the next cycle. This is 2 cycles from accept to response.
  - Error-decode path: ready_o high in the cycle after accept. This is 1 cycle.
  - Timeout path: ready_o high TIMEOUT+1 cycles after entering ACCESS.
- Timeout counter width is $clog2(TIMEOUT+1). It clears on every entry to ACCESS.
- data_o and err_o change only when entering RESP. Between responses they hold their last value.

## Structure
- Package mem_bus_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_bus_state_t.
  - Selector constants SEL_MEM=0, SEL_SPRITE=2, SEL_UART=3.
  - Default PRESENT, READABLE and WRITABLE masks.
- One sub-module, mem_bus_timeout, contains the clear/enable/terminal-count counter parametrised by TIMEOUT.
- The decode, FSM and target fan-out stay in mem_bus_router.

## Test plan
- Read, selector 0, address 0x0000_0004, target 0 ready in the first ACCESS cycle with data 0xDEAD_BEEF. Expect slv_MR_o=4'b0001, slv_address_o[0]=4, ready_o exactly 2 cycles after accept, data_o=0xDEAD_BEEF, err_o=0.
- Write 0x1234 to address 0x0000_0808 (selector 2), target 2 ready after 3 wait cycles. Expect slv_MW_o=4'b0100 held for 4 cycles, slv_data_o[2]=0x1234, ready_o with err_o=0, data_o=0.
- Each illegal access separately, all with no strobes asserted:
  - Read of selector 1 (unmapped).
  - Write to 0x0000_0C00 (UART, read-only).
  - MR_i and MW_i both high.
  - Each one expects ready_o 1 cycle after accept and err_o=1. After the three accesses, err_count_o=3.
- TIMEOUT=15 with target 3 never ready. Expect ready_o and err_o 16 cycles after ACCESS entry and the strobe dropped in RESP. Separately, ready arriving exactly at count 15 gives err_o=0.
- rst_i asserted in the 2nd ACCESS cycle. Expect all outputs 0 next cycle and no ready_o. A following read completes normally.
- 260 consecutive illegal accesses. Expect err_count_o to stop at 255.
